// File: rtl/avalon_ram_pkg.sv
// Shared types and constants for the Avalon-MM bench RAM.
// The stall-count LFSR step lives here so the RAM and its LFSR agree on the polynomial.
package avalon_ram_pkg;

    typedef logic [31:0] size_t;

    typedef enum logic [1:0] {RAM_IDLE, RAM_WAIT, RAM_DONE} ram_state_t;

    localparam size_t RESET_VECTOR     = 32'hBFC00000;
    localparam size_t RAM_ERR_READDATA = 32'h0;

    // WAIT_CYCLES (<=15) plus up to 3 random extra stalls
    localparam int unsigned CNT_W     = 5;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    // Maximal-length 8-bit Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/avalon_ram_if.sv
// Avalon-MM bus between the CPU master and the bench RAM slave.
interface avalon_ram_if;
    import avalon_ram_pkg::*;

    logic       read;
    logic       write;
    logic [3:0] byteenable;
    size_t      address;
    size_t      writedata;
    size_t      readdata;
    logic       waitrequest;
    logic       access_error;

    modport master (
        output read, write, byteenable, address, writedata,
        input  readdata, waitrequest, access_error
    );

    modport slave (
        input  read, write, byteenable, address, writedata,
        output readdata, waitrequest, access_error
    );

endinterface

// File: rtl/avalon_ram_wait_lfsr.sv
// Random extra-stall source for avalon_ram; only built when RAM_RANDOM_WAIT_EN is defined.
`ifdef RAM_RANDOM_WAIT_EN
module ram_wait_lfsr
    import avalon_ram_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule
`endif

// File: rtl/avalon_ram.sv
// Word-addressed Avalon-MM slave RAM with waitrequest stalls and access checking.
// Define RAM_RANDOM_WAIT_EN to add 0..3 LFSR-driven extra stalls per transfer.
module avalon_ram
  import avalon_ram_pkg::*;
#(
  parameter string       RAM_FILE    = "test/ram_test_01.hex",
  parameter size_t       RAM_OFFSET  = RESET_VECTOR,
  parameter int unsigned RAM_WORDS   = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          reset,
  avalon_ram_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(RAM_WORDS);

  logic [31:0]      mem [RAM_WORDS];

  ram_state_t       state, state_next;
  logic [CNT_W-1:0] count, count_next, load_count;
  logic             complete;
  size_t            offset;
  logic [IDX_W-1:0] index;
  logic             illegal;
  size_t            readdata;
  logic             access_error;

  assign offset  = bus.address - RAM_OFFSET;
  assign index   = offset[IDX_W+1:2];
  assign illegal = (bus.address[1:0] != 2'b00) || (bus.address < RAM_OFFSET) ||
                   ((offset >> 2) >= size_t'(RAM_WORDS));

`ifdef RAM_RANDOM_WAIT_EN
  logic [7:0] lfsr_value;
  logic       accept;

  assign accept     = (state == RAM_IDLE) && (bus.read || bus.write);
  assign load_count = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr_value[1:0]);

  ram_wait_lfsr u_wait_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .value   (lfsr_value)
  );
`else
  assign load_count = CNT_W'(WAIT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RAM_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // complete marks the edge that enters DONE: memory and readdata update there
  always_comb begin
    state_next = state;
    count_next = count;
    complete   = 1'b0;
    unique case (state)
      RAM_IDLE: begin
        if (bus.read || bus.write) begin
          count_next = load_count;
          if (load_count != '0) begin
            state_next = RAM_WAIT;
          end else begin
            state_next = RAM_DONE;
            complete   = 1'b1;
          end
        end
      end
      RAM_WAIT: begin
        if (!(bus.read || bus.write)) begin
          state_next = RAM_IDLE;
        end else begin
          count_next = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state_next = RAM_DONE;
            complete   = 1'b1;
          end
        end
      end
      RAM_DONE: state_next = RAM_IDLE;
      default:  state_next = RAM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata     <= '0;
      access_error <= 1'b0;
    end else begin
      access_error <= complete && (illegal || (bus.read && bus.write));
      if (complete && bus.read && !bus.write) begin
        readdata <= illegal ? RAM_ERR_READDATA : mem[index];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && complete && bus.write && !illegal) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (bus.byteenable[n]) mem[index][8*n +: 8] <= bus.writedata[8*n +: 8];
      end
    end
  end

  assign bus.readdata     = readdata;
  assign bus.access_error = access_error;
  assign bus.waitrequest  = (state != RAM_DONE);

endmodule

// File: tb/tb_avalon_ram.sv
// Directed bench for avalon_ram: three instances with WAIT_CYCLES 1, 2 and 4.
module tb_avalon_ram;
    import avalon_ram_pkg::*;

`ifdef RAM_RANDOM_WAIT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] lf [3];

    avalon_ram_if bus1 ();
    avalon_ram_if bus2 ();
    avalon_ram_if bus4 ();

    avalon_ram #(.RAM_FILE(""), .RAM_OFFSET(BASE), .RAM_WORDS(256), .WAIT_CYCLES(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    avalon_ram #(.RAM_FILE(""), .RAM_OFFSET(BASE), .RAM_WORDS(256), .WAIT_CYCLES(2))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));
    avalon_ram #(.RAM_FILE(""), .RAM_OFFSET(BASE), .RAM_WORDS(256), .WAIT_CYCLES(4))
        dut4 (.clk(clk), .reset(reset), .bus(bus4));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int wc_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    // Expected stall cycles for the next accepted request; steps the reference LFSR
    function automatic int expect_stalls(input int d);
        int         s;
        logic [7:0] v;
        v = lf[d];
        s = wc_of(d) + 1 + (FEAT ? int'(v[1:0]) : 0);
        lf[d] = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return s;
    endfunction

    function automatic logic wreq(input int d);
        case (d)
            0:       return bus1.waitrequest;
            1:       return bus2.waitrequest;
            default: return bus4.waitrequest;
        endcase
    endfunction

    function automatic logic [31:0] rdat(input int d);
        case (d)
            0:       return bus1.readdata;
            1:       return bus2.readdata;
            default: return bus4.readdata;
        endcase
    endfunction

    function automatic logic aerr(input int d);
        case (d)
            0:       return bus1.access_error;
            1:       return bus2.access_error;
            default: return bus4.access_error;
        endcase
    endfunction

    task automatic drive(input int d, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        case (d)
            0: begin
                bus1.read = rd; bus1.write = wr; bus1.address = addr;
                bus1.writedata = wd; bus1.byteenable = be;
            end
            1: begin
                bus2.read = rd; bus2.write = wr; bus2.address = addr;
                bus2.writedata = wd; bus2.byteenable = be;
            end
            default: begin
                bus4.read = rd; bus4.write = wr; bus4.address = addr;
                bus4.writedata = wd; bus4.byteenable = be;
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) lf[i] = 8'hA5;
    endtask

    // One full transfer; returns stall cycles seen and the DONE-cycle outputs
    task automatic xfer(input int d, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                        output int stalls, output logic [31:0] rdata, output logic err);
        int exp_st;
        exp_st = expect_stalls(d);
        drive(d, rd, wr, addr, wd, be);
        stalls = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!wreq(d)) break;
            stalls++;
        end
        rdata = rdat(d);
        err   = aerr(d);
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        check("stall_count", 32'(stalls), 32'(exp_st));
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        logic        er;
        int          seq [64];
        logic [31:0] a;

        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_waitrequest", 32'(bus2.waitrequest), 32'd1);
        check("rst_readdata", bus2.readdata, 32'h0);
        check("rst_access_error", 32'(bus2.access_error), 32'd0);
        check("rst_state", 32'(dut2.state), 32'(RAM_IDLE));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) lf[i] = 8'hA5;

        // Preload
        xfer(1, 0, 1, BASE,       32'h3C08BFC0, 4'hF, st, rd, er);
        xfer(1, 0, 1, BASE + 16,  32'h11223344, 4'hF, st, rd, er);
        xfer(1, 0, 1, BASE + 4,   32'h01010101, 4'hF, st, rd, er);

        // 1: basic read with WAIT_CYCLES=2
        xfer(1, 1, 0, BASE, 32'h0, 4'h0, st, rd, er);
        check("t1_readdata", rd, 32'h3C08BFC0);
        check("t1_access_error", 32'(er), 32'd0);

        // 2: byte-lane write, readdata unaffected by the write
        xfer(1, 0, 1, BASE + 16, 32'hAABBCCDD, 4'b0101, st, rd, er);
        check("t2_write_err", 32'(er), 32'd0);
        check("t2_readdata_held", rd, 32'h3C08BFC0);
        xfer(1, 0, 1, BASE + 16, 32'hFFFFFFFF, 4'b0000, st, rd, er);
        check("t2_be0_err", 32'(er), 32'd0);
        xfer(1, 1, 0, BASE + 16, 32'h0, 4'h0, st, rd, er);
        check("t2_readback", rd, 32'h11BB33DD);

        // 3: illegal accesses
        xfer(1, 1, 0, BASE + 2, 32'h0, 4'h0, st, rd, er);
        check("t3_misaligned_data", rd, 32'h0);
        check("t3_misaligned_err", 32'(er), 32'd1);
        xfer(1, 1, 0, BASE + 4 * 256, 32'h0, 4'h0, st, rd, er);
        check("t3_range_data", rd, 32'h0);
        check("t3_range_err", 32'(er), 32'd1);
        xfer(1, 1, 0, BASE - 4, 32'h0, 4'h0, st, rd, er);
        check("t3_under_err", 32'(er), 32'd1);
        xfer(1, 0, 1, BASE + 2, 32'hFFFFFFFF, 4'hF, st, rd, er);
        check("t3_badwrite_err", 32'(er), 32'd1);
        xfer(1, 0, 1, BASE + 4 * 255, 32'h5A5A0FF0, 4'hF, st, rd, er);
        check("t3_lastword_werr", 32'(er), 32'd0);
        xfer(1, 1, 0, BASE + 4 * 255, 32'h0, 4'h0, st, rd, er);
        check("t3_lastword_data", rd, 32'h5A5A0FF0);
        xfer(1, 1, 0, BASE, 32'h0, 4'h0, st, rd, er);
        check("t3_legal_data", rd, 32'h3C08BFC0);
        check("t3_legal_err", 32'(er), 32'd0);

        // 4: read and write together
        xfer(1, 1, 1, BASE + 4, 32'hCAFEF00D, 4'hF, st, rd, er);
        check("t4_err", 32'(er), 32'd1);
        check("t4_readdata_held", rd, 32'h3C08BFC0);
        xfer(1, 1, 0, BASE + 4, 32'h0, 4'h0, st, rd, er);
        check("t4_readback", rd, 32'hCAFEF00D);

        // 5: aborted write (dropped request, then reset) with WAIT_CYCLES=4
        xfer(2, 0, 1, BASE + 8, 32'h12345678, 4'hF, st, rd, er);
        void'(expect_stalls(2));
        drive(2, 1'b0, 1'b1, BASE + 8, 32'hDEADBEEF, 4'hF);
        @(posedge clk); #1;
        check("t5_drop_stall1", 32'(wreq(2)), 32'd1);
        @(posedge clk); #1;
        check("t5_drop_stall2", 32'(wreq(2)), 32'd1);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        check("t5_drop_state", 32'(dut4.state), 32'(RAM_IDLE));
        check("t5_drop_waitrequest", 32'(wreq(2)), 32'd1);
        check("t5_drop_err", 32'(aerr(2)), 32'd0);
        xfer(2, 1, 0, BASE + 8, 32'h0, 4'h0, st, rd, er);
        check("t5_drop_mem", rd, 32'h12345678);

        void'(expect_stalls(2));
        drive(2, 1'b0, 1'b1, BASE + 8, 32'h0BADF00D, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_rst_inwait", 32'(dut4.state), 32'(RAM_WAIT));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) lf[i] = 8'hA5;
        check("t5_rst_state", 32'(dut4.state), 32'(RAM_IDLE));
        check("t5_rst_waitrequest", 32'(wreq(2)), 32'd1);
        xfer(2, 1, 0, BASE + 8, 32'h0, 4'h0, st, rd, er);
        check("t5_rst_mem", rd, 32'h12345678);

        // 6: stall-count sequence with WAIT_CYCLES=1, repeatable after reset
        for (int i = 0; i < 8; i++) begin
            a = BASE + (32'(i) << 2);
            xfer(0, 0, 1, a, 32'hA5A50000 ^ (32'(i) * 32'h01010101), 4'hF, st, rd, er);
        end
        do_reset();
        for (int i = 0; i < 64; i++) begin
            a = BASE + (32'(i % 8) << 2);
            xfer(0, 1, 0, a, 32'h0, 4'h0, st, rd, er);
            seq[i] = st;
            check("t6_data", rd, 32'hA5A50000 ^ (32'(i % 8) * 32'h01010101));
            check("t6_range", 32'((st >= 2) && (st <= 5)), 32'd1);
        end
        do_reset();
        for (int i = 0; i < 64; i++) begin
            a = BASE + (32'(i % 8) << 2);
            xfer(0, 1, 0, a, 32'h0, 4'h0, st, rd, er);
            check("t6_repeat", 32'(st), 32'(seq[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
